mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multicycle signed multiply/divide unit for the multicycle CPU datapath.
//  Executes MIPS mult/div on register operands A and B.
//  Holds the result in the architectural HI/LO registers.
//  HI and LO feed the register-write-source mux (mfhi/mflo paths), upstream of the register bank.
//  The control FSM starts an operation and stalls on busy until done pulses.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      synchronous, active-high reset
//  start_mult  in   1      one-cycle request: signed a*b
//  start_div   in   1      one-cycle request: signed a/b
//  a           in   WIDTH  operand A (rs); sampled only on the accepting edge
//  b           in   WIDTH  operand B (rt); sampled only on the accepting edge
//  hi          out  WIDTH  HI register: product[2W-1:W] or remainder
//  lo          out  WIDTH  LO register: product[W-1:0] or quotient
//  busy        out  1      operation in progress
//  done        out  1      one-cycle pulse; hi/lo valid in the same cycle
//  div_zero    out  1      last accepted div had b==0; held until next accepted start
// BEHAVIOUR
//  Interface decision: one clock (clk); reset is synchronous and active-high (reset).
//  Reset: state=IDLE; hi=lo=0; busy=done=div_zero=0. Internal counters/accumulators cleared.
//  States:
//   IDLE: start_mult wins if both starts are high; start_div is then ignored.
//    Accepting edge: latch a and b, clear div_zero, load counter=WIDTH.
//    Next state is MULT or DIV.
//    div with b==0 goes to DZ instead.
//   MULT: radix-2 Booth, one step per cycle over a 2W+1 bit accumulator.
//    Arithmetic shift right each step.
//    After WIDTH steps, go to FIN.
//   DIV: restoring division on magnitudes, one quotient bit per cycle.
//    After WIDTH steps, apply signs and go to FIN.
//   FIN: hi/lo written; done=1 for exactly this cycle; busy=0; next state IDLE.
//   DZ: done=1 and div_zero=1 for this cycle; hi/lo unchanged; next state IDLE.
//    div_zero stays 1 afterwards until the next accepted start.
//  Latency:
//   mult/div: done is high in the cycle after the 33rd rising edge counted from the accepting edge (edge 0).
//   div-by-zero: done is high in the cycle after edge 1.
//  busy: high from edge 0 until done is asserted. busy and done are never high together.
//  Starts while not IDLE (busy or FIN/DZ) are ignored; they are not queued.
//  Arithmetic (all signed two's complement):
//   mult: {hi,lo} = full 2W-bit product; no overflow possible.
//   div: lo = quotient truncated toward zero; hi = remainder with the sign of a.
//    Invariant: a == lo*b + hi.
//   Most-negative / -1: lo=0x80000000, hi=0 (wraps, no trap).
//  hi/lo change only on a FIN transition or on reset. They hold indefinitely otherwise.
//  Reset mid-operation: operation aborted; no done pulse; outputs take reset values next cycle.
//  a and b may change after the accepting edge without affecting the result.
// TESTING
//  1 mult a=7, b=0xFFFFFFFD (-3) -> done at edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low in done cycle.
//  2 mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
//    Then mult 0xFFFFFFFF*0xFFFFFFFF -> hi=0, lo=1.
//  3 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    Then div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4 hi/lo=0x11/0x22; div a=5, b=0 -> done and div_zero at edge 1.
//    hi/lo stay 0x11/0x22; div_zero stays 1 until next mult accepted.
//  5 start_mult and start_div high together with a=3, b=4 -> mult executes; lo=12, hi=0.
//    start_div pulsed at edge 10 is ignored; exactly one done.
//  6 mult a=9, b=9; reset high at edge 10 for 1 cycle -> busy=0, hi=lo=0, no done.
//    New mult 9*9 then gives lo=81 at edge 33 from its own start.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the CPU control datapath and the multiply/divide unit.
// The control side drives starts and operands; the unit returns HI/LO and status.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start_mult, start_div, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit owning the HI/LO registers.
// One step per clock; results land in HI/LO on the cycle done pulses.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIN, DZ_WAIT, DZ} state_t;

    state_t                  state;
    state_t                  state_next;

    logic signed [2*WIDTH:0] acc;
    logic                    booth_prev;
    logic signed [WIDTH-1:0] mcand;
    logic [WIDTH:0]          rem;
    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        dvs;
    logic                    neg_quo;
    logic                    neg_rem;
    logic [CNT_W-1:0]        count;
    logic [WIDTH-1:0]        hi_r;
    logic [WIDTH-1:0]        lo_r;
    logic                    div_zero_r;

    logic                    accept_mult;
    logic                    accept_div;
    logic signed [WIDTH:0]   booth_upper;
    logic signed [2*WIDTH:0] booth_next;
    logic [WIDTH:0]          div_shift;
    logic [WIDTH:0]          div_sub;
    logic                    div_fit;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // Most-negative input maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return apply_sign(x, x[WIDTH-1]);
    endfunction

    assign accept_mult = (state == IDLE) && bus.start_mult;
    assign accept_div  = (state == IDLE) && !bus.start_mult && bus.start_div;

    always_comb begin
        booth_upper = acc[2*WIDTH:WIDTH];
        case ({acc[0], booth_prev})
            2'b10:   booth_upper = acc[2*WIDTH:WIDTH] - {mcand[WIDTH-1], mcand};
            2'b01:   booth_upper = acc[2*WIDTH:WIDTH] + {mcand[WIDTH-1], mcand};
            default: booth_upper = acc[2*WIDTH:WIDTH];
        endcase
        booth_next = $signed({booth_upper, acc[WIDTH-1:0]}) >>> 1;

        // Bring down the next dividend bit from the top of the quotient shifter.
        div_shift = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
        div_sub   = div_shift - {1'b0, dvs};
        div_fit   = div_shift >= {1'b0, dvs};
    end

    always_comb begin
        state_next   = state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept_mult)
                    state_next = MULT;
                else if (accept_div)
                    state_next = (bus.b == '0) ? DZ_WAIT : DIV;
            end
            MULT: begin
                bus.busy = 1'b1;
                if (count == '0)
                    state_next = FIN;
            end
            DIV: begin
                bus.busy = 1'b1;
                if (count == '0)
                    state_next = FIN;
            end
            DZ_WAIT: begin
                bus.busy   = 1'b1;
                state_next = DZ;
            end
            FIN: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            DZ: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            booth_prev <= 1'b0;
            mcand      <= '0;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            count      <= '0;
            hi_r       <= '0;
            lo_r       <= '0;
            div_zero_r <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept_mult) begin
                        mcand      <= bus.a;
                        acc        <= {{(WIDTH+1){1'b0}}, bus.b};
                        booth_prev <= 1'b0;
                        count      <= CNT_W'(WIDTH);
                        div_zero_r <= 1'b0;
                    end else if (accept_div) begin
                        quo        <= magnitude(bus.a);
                        dvs        <= magnitude(bus.b);
                        rem        <= '0;
                        neg_quo    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        neg_rem    <= bus.a[WIDTH-1];
                        count      <= CNT_W'(WIDTH);
                        div_zero_r <= 1'b0;
                    end
                end
                MULT: begin
                    if (count != '0) begin
                        acc        <= booth_next;
                        booth_prev <= acc[0];
                        count      <= count - 1'b1;
                    end else begin
                        {hi_r, lo_r} <= acc[2*WIDTH-1:0];
                    end
                end
                DIV: begin
                    if (count != '0) begin
                        rem   <= div_fit ? div_sub : div_shift;
                        quo   <= {quo[WIDTH-2:0], div_fit};
                        count <= count - 1'b1;
                    end else begin
                        hi_r <= apply_sign(rem[WIDTH-1:0], neg_rem);
                        lo_r <= apply_sign(quo, neg_quo);
                    end
                end
                DZ_WAIT: div_zero_r <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.div_zero = div_zero_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes reference results, a monitor pops them on done.
// Reference results come from plain 64-bit signed arithmetic.
module tb_mult_div_unit;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           done_cyc;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   op_id = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;
    exp_t sb[$];
    exp_t got;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                got = sb.pop_front();
                check($sformatf("op%0d_hi", got.id), bus.hi, got.hi);
                check($sformatf("op%0d_lo", got.id), bus.lo, got.lo);
                check($sformatf("op%0d_div_zero", got.id), bus.div_zero, got.dz);
                check($sformatf("op%0d_latency", got.id), cyc, got.done_cyc);
                check($sformatf("op%0d_busy_in_done", got.id), bus.busy, 0);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) return;
        end
        total++;
        bad++;
        $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
    endtask

    task automatic issue(input bit m, input bit d, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int acc_cyc);
        exp_t   e;
        longint pa;
        longint pb;
        longint pr;
        bit     is_mult;
        wait_idle();
        bus.start_mult = m;
        bus.start_div  = d;
        bus.a          = av;
        bus.b          = bv;
        @(posedge clk);
        #1;
        acc_cyc        = cyc;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = $urandom;
        bus.b          = $urandom;
        is_mult        = m;
        pa = longint'($signed(av));
        pb = longint'($signed(bv));
        e.dz = 1'b0;
        e.done_cyc = acc_cyc + 33;
        if (is_mult) begin
            pr = pa * pb;
            mhi = pr[63:32];
            mlo = pr[31:0];
        end else if (bv == '0) begin
            e.dz = 1'b1;
            e.done_cyc = acc_cyc + 1;
        end else begin
            pr = pa / pb;
            mlo = pr[31:0];
            pr = pa % pb;
            mhi = pr[31:0];
        end
        e.hi = mhi;
        e.lo = mlo;
        e.id = op_id;
        op_id++;
        sb.push_back(e);
        check("busy_after_accept", bus.busy, 1);
        check("div_zero_cleared_on_accept", bus.div_zero, 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'h0000_0001;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int acc;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_div_zero", bus.div_zero, 0);
        reset = 1'b0;

        issue(1, 0, 32'd7, 32'hFFFF_FFFD, acc);
        wait_idle();
        check("t1_hi", bus.hi, 32'hFFFF_FFFF);
        check("t1_lo", bus.lo, 32'hFFFF_FFEB);

        issue(1, 0, 32'h8000_0000, 32'h8000_0000, acc);
        wait_idle();
        check("t2a_hi", bus.hi, 32'h4000_0000);
        check("t2a_lo", bus.lo, 32'h0000_0000);
        issue(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
        wait_idle();
        check("t2b_hi", bus.hi, 32'h0);
        check("t2b_lo", bus.lo, 32'h1);

        issue(0, 1, 32'hFFFF_FFF9, 32'd2, acc);
        wait_idle();
        check("t3a_hi", bus.hi, 32'hFFFF_FFFF);
        check("t3a_lo", bus.lo, 32'hFFFF_FFFD);
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, acc);
        wait_idle();
        check("t3b_hi", bus.hi, 32'h0);
        check("t3b_lo", bus.lo, 32'h8000_0000);

        issue(0, 1, 32'h0000_2211, 32'h0000_0100, acc);
        wait_idle();
        check("t4_pre_hi", bus.hi, 32'h11);
        check("t4_pre_lo", bus.lo, 32'h22);
        issue(0, 1, 32'd5, 32'd0, acc);
        wait_idle();
        repeat (4) @(negedge clk);
        check("t4_hold_hi", bus.hi, 32'h11);
        check("t4_hold_lo", bus.lo, 32'h22);
        check("t4_div_zero_held", bus.div_zero, 1);

        issue(1, 1, 32'd3, 32'd4, acc);
        while (cyc < acc + 9) @(negedge clk);
        bus.start_div = 1'b1;
        bus.b = 32'd0;
        @(negedge clk);
        bus.start_div = 1'b0;
        wait_idle();
        check("t5_hi", bus.hi, 32'd0);
        check("t5_lo", bus.lo, 32'd12);
        repeat (3) @(negedge clk);

        issue(1, 0, 32'd9, 32'd9, acc);
        while (cyc < acc + 9) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy_after_reset", bus.busy, 0);
        check("t6_done_after_reset", bus.done, 0);
        check("t6_hi_after_reset", bus.hi, 0);
        check("t6_lo_after_reset", bus.lo, 0);
        repeat (40) @(negedge clk);
        issue(1, 0, 32'd9, 32'd9, acc);
        wait_idle();
        check("t6_lo", bus.lo, 32'd81);
        check("t6_hi", bus.hi, 32'd0);

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            bit           rm;
            ra = pick();
            rb = pick();
            rm = $urandom_range(0, 1);
            issue(rm, !rm, ra, rb, acc);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
